muldiv_seq_unit: RTL and testbench

MULDIV_SEQ_UNIT -- requirements
Module: muldiv_seq_unit

---
 rtl/muldiv_seq_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_seq_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_unit.sv
// Sequential 32-bit signed multiply / divide unit.
// Uses one iteration per clock on operand magnitudes: shift-add for multiply,
// restoring division for divide. Each operation takes 32 cycles, then raises a
// one-cycle ready strobe.
module muldiv_seq_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam int unsigned W   = 32;
  localparam int unsigned MW  = W + 1;   // magnitude width, holds |0x80000000|
  localparam int unsigned PW  = 2 * W;   // full product width
  localparam int unsigned CW  = 5;       // iteration counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            op_div_q;
  logic            neg_q;
  logic [PW-1:0]   mcand_q;
  logic [W-1:0]    mplier_q;
  logic [PW-1:0]   prod_q;
  logic [MW-1:0]   divisor_q;
  logic [W-1:0]    quot_q;
  logic [MW-1:0]   rem_q;

  logic            start_c;
  logic [MW-1:0]   a_mag_c;
  logic [MW-1:0]   b_mag_c;
  logic [PW-1:0]   prod_d;
  logic [MW-1:0]   rem_sh_c;
  logic            ge_c;
  logic [MW-1:0]   rem_d;
  logic [W-1:0]    quot_d;
  logic [PW-1:0]   prod_signed_c;
  logic [W-1:0]    quot_signed_c;
  logic [W-1:0]    res_fin_c;
  logic            exc_fin_c;

  // Start request and operand magnitudes.
  always_comb begin
    start_c = (state_q != S_RUN) && (ctrl_MULT || ctrl_DIV);
    a_mag_c = data_operandA[W-1] ? (~{1'b1, data_operandA} + MW'(1)) : {1'b0, data_operandA};
    b_mag_c = data_operandB[W-1] ? (~{1'b1, data_operandB} + MW'(1)) : {1'b0, data_operandB};
  end

  // One multiply step and one restoring-divide step.
  always_comb begin
    prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    rem_sh_c = MW'({rem_q, quot_q[W-1]});
    ge_c     = (rem_sh_c >= divisor_q);
    rem_d    = ge_c ? (rem_sh_c - divisor_q) : rem_sh_c;
    quot_d   = {quot_q[W-2:0], ge_c};
  end

  // Final signed result and exception, taken from the last iteration's values.
  always_comb begin
    prod_signed_c = neg_q ? (PW'(0) - prod_d) : prod_d;
    quot_signed_c = neg_q ? (W'(0) - quot_d) : quot_d;
    res_fin_c     = prod_signed_c[W-1:0];
    exc_fin_c     = (prod_signed_c[PW-1:W] != {W{prod_signed_c[W-1]}});
    if (op_div_q) begin
      if (divisor_q == MW'(0)) begin
        res_fin_c = W'(0);
        exc_fin_c = 1'b1;
      end else begin
        res_fin_c = quot_signed_c;
        // A positive quotient of magnitude 2^31 does not fit.
        exc_fin_c = !neg_q && quot_d[W-1];
      end
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      op_div_q       <= 1'b0;
      neg_q          <= 1'b0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      prod_q         <= '0;
      divisor_q      <= '0;
      quot_q         <= '0;
      rem_q          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          cnt_q    <= cnt_q + CW'(1);
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[PW-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[W-1:1]};
          rem_q    <= rem_d;
          quot_q   <= quot_d;
          if (cnt_q == CW'(W - 1)) begin
            state_q        <= S_DONE;
            data_result    <= res_fin_c;
            data_exception <= exc_fin_c;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
          end
        end
        default: begin
          data_resultRDY <= 1'b0;
          if (start_c) begin
            state_q   <= S_RUN;
            busy      <= 1'b1;
            cnt_q     <= '0;
            op_div_q  <= !ctrl_MULT;
            neg_q     <= data_operandA[W-1] ^ data_operandB[W-1];
            mcand_q   <= PW'(a_mag_c);
            mplier_q  <= b_mag_c[W-1:0];
            prod_q    <= '0;
            divisor_q <= b_mag_c;
            quot_q    <= a_mag_c[W-1:0];
            rem_q     <= '0;
          end else begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit, using random and directed operations.
module tb_muldiv_seq_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int errors = 0;
  int checks = 0;

  muldiv_seq_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference: signed arithmetic done directly on 64-bit and 32-bit integers.
  function automatic void model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'h0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = 32'h80000000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [6];
    specials[0] = 32'h0;
    specials[1] = 32'h1;
    specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h80000000;
    specials[4] = 32'h7FFFFFFF;
    specials[5] = 32'h00010000;
    case ($urandom_range(0, 3))
      0:       return specials[$urandom_range(0, 5)];
      1:       return 32'($signed(16'($urandom)));
      default: return $urandom;
    endcase
  endfunction

  // Launch one operation (caller is 1 time unit after a rising edge) and wait for RDY.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc, output int lat,
                        output int busy_n, output logic busy_done);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat    = 0;
    busy_n = 0;
    while (!data_resultRDY && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clock); #1;
      lat++;
    end
    res       = data_result;
    exc       = data_exception;
    busy_done = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    #2;
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got=%b exp=0", data_exception); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++; $display("FAIL idle_quiet got busy=%b rdy=%b exp 0 0", busy, data_resultRDY);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic        vd [7];
    logic [31:0] er [7];
    logic        ee [7];
    logic [31:0] res;
    logic        exc, bd;
    int          lat, bn;
    va[0]=32'd7;        vb[0]=32'hFFFFFFFA; vd[0]=0; er[0]=32'hFFFFFFD6; ee[0]=0;
    va[1]=32'h00010000; vb[1]=32'h00010000; vd[1]=0; er[1]=32'h00000000; ee[1]=1;
    va[2]=32'h80000000; vb[2]=32'h1;        vd[2]=0; er[2]=32'h80000000; ee[2]=0;
    va[3]=32'hFFFFFFF9; vb[3]=32'h2;        vd[3]=1; er[3]=32'hFFFFFFFD; ee[3]=0;
    va[4]=32'd5;        vb[4]=32'h0;        vd[4]=1; er[4]=32'h00000000; ee[4]=1;
    va[5]=32'h80000000; vb[5]=32'hFFFFFFFF; vd[5]=1; er[5]=32'h80000000; ee[5]=1;
    va[6]=32'h80000000; vb[6]=32'h1;        vd[6]=1; er[6]=32'h80000000; ee[6]=0;
    for (int i = 0; i < 7; i++) begin
      run_op(!vd[i], vd[i], va[i], vb[i], res, exc, lat, bn, bd);
      checks++; if (res !== er[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, er[i]); end
      checks++; if (exc !== ee[i]) begin errors++; $display("FAIL dir%0d_exc got=%b exp=%b", i, exc, ee[i]); end
      checks++; if (lat != 32) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=32", i, lat); end
      if (i == 0) begin
        checks++; if (bn != 32) begin errors++; $display("FAIL dir0_busy_cycles got=%0d exp=32", bn); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL dir0_busy_in_done got=%b exp=0", bd); end
      end
      @(posedge clock); #1;
      checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL dir%0d_rdy_one_cycle got=%b exp=0", i, data_resultRDY); end
      checks++; if (data_result !== er[i]) begin errors++; $display("FAIL dir%0d_hold got=%h exp=%h", i, data_result, er[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, er;
    logic        exc, ee, bd, m, d;
    int          lat, bn, sel;
    for (int i = 0; i < 40; i++) begin
      a   = pick_operand();
      b   = pick_operand();
      sel = $urandom_range(0, 2);
      m   = (sel != 1);
      d   = (sel != 0);
      model(!m, a, b, er, ee);
      run_op(m, d, a, b, res, exc, lat, bn, bd);
      checks++; if (res !== er || exc !== ee || lat != 32) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got res=%h exc=%b lat=%0d exp res=%h exc=%b lat=32",
                 i, sel, a, b, res, exc, lat, er, ee);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_ignore_in_run();
    logic [31:0] er;
    logic        ee;
    int          lat, extra;
    model(1'b0, 32'd1234, 32'hFFFFF000, er, ee);
    data_operandA = 32'd1234;
    data_operandB = 32'hFFFFF000;
    ctrl_MULT = 1'b1;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    lat = 0;
    while (!data_resultRDY && lat < 40) begin
      if (lat == 9) begin
        ctrl_DIV = 1'b1; data_operandA = 32'd99; data_operandB = 32'd3;
      end else begin
        ctrl_DIV = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    ctrl_DIV = 1'b0;
    checks++; if (lat != 32) begin errors++; $display("FAIL ignore_latency got=%0d exp=32", lat); end
    checks++; if (data_result !== er || data_exception !== ee) begin
      errors++; $display("FAIL ignore_result got=%h/%b exp=%h/%b", data_result, data_exception, er, ee);
    end
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (data_resultRDY) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_second_rdy got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, er1, er2;
    logic        exc, ee1, ee2, bd;
    int          lat, bn;
    model(1'b0, 32'd300, 32'd500, er1, ee1);
    model(1'b0, 32'hFFFFFF00, 32'd77, er2, ee2);
    run_op(1'b1, 1'b0, 32'd300, 32'd500, res, exc, lat, bn, bd);
    checks++; if (res !== er1 || exc !== ee1 || lat != 32) begin
      errors++; $display("FAIL b2b_first got=%h/%b lat=%0d exp=%h/%b lat=32", res, exc, lat, er1, ee1);
    end
    // Issued while in DONE: starts on the edge leaving DONE.
    run_op(1'b1, 1'b0, 32'hFFFFFF00, 32'd77, res, exc, lat, bn, bd);
    checks++; if (res !== er2 || exc !== ee2) begin
      errors++; $display("FAIL b2b_second got=%h/%b exp=%h/%b", res, exc, er2, ee2);
    end
    checks++; if (lat != 32 || bn != 32) begin
      errors++; $display("FAIL b2b_timing got lat=%0d busy=%0d exp 32 32", lat, bn);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        exc, bd;
    int          lat, bn, extra;
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (15) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checks++; if (data_result !== 32'h0 || data_exception !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got=%h/%b exp=0/0", data_result, data_exception);
    end
    checks++; if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl got busy=%b rdy=%b exp 0 0", busy, data_resultRDY);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (data_resultRDY || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL midreset_no_rdy got=%0d exp=0", extra); end
    run_op(1'b0, 1'b1, 32'd100, 32'd7, res, exc, lat, bn, bd);
    checks++; if (res !== 32'd14 || exc !== 1'b0 || lat != 32) begin
      errors++; $display("FAIL post_reset_div got=%h/%b lat=%0d exp=0000000e/0 lat=32", res, exc, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
